simd_mac_pipelined: RTL and testbench



---
 rtl/pirdsp_mac_pkg.sv | 30 +++
 rtl/simd_product_unit.sv | 103 ++++++++++
 rtl/simd_mac_pipelined.sv | 91 +++++++++
 tb/tb_simd_mac_pipelined.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pirdsp_mac_pkg.sv
// Shared constants and types for the PIRDSP pipelined multi-mode MAC.
package pirdsp_mac_pkg;

  localparam int unsigned OP_W     = 54;
  localparam int unsigned FULL_A_W = 27;
  localparam int unsigned FULL_B_W = 18;

  localparam int unsigned LANE9_W = 9;
  localparam int unsigned LANE9_N = 6;
  localparam int unsigned LANE4_W = 4;
  localparam int unsigned LANE4_N = 12;
  localparam int unsigned LANE2_W = 2;
  localparam int unsigned LANE2_N = 24;

  typedef enum logic [1:0] {
    MODE_FULL = 2'b00,
    MODE_SUM9 = 2'b01,
    MODE_SUM4 = 2'b10,
    MODE_SUM2 = 2'b11
  } mac_mode_e;

  // Per-beat side-band that travels alongside the product.
  typedef struct packed {
    logic      valid;
    logic      is_signed;
    logic      clr;
    mac_mode_e mode;
  } mac_side_t;

endpackage

// File: rtl/simd_product_unit.sv
// Lane slicing, per-lane multiplies, reduction and PIPE_STAGES register stages.
module simd_product_unit
  import pirdsp_mac_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ACC_W       = 48
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [1:0]        mode,
  input  logic              clr,
  output logic [ACC_W-1:0]  p,
  output logic              p_valid,
  output logic              p_signed,
  output logic              p_clr,
  output logic [1:0]        p_mode
);

  logic signed [ACC_W-1:0] prod_c;
  logic signed [46:0]      fa, fb, fp;
  logic signed [19:0]      a9, b9, p9;
  logic signed [9:0]       a4, b4, p4;
  logic signed [5:0]       a2, b2, p2;

  logic [ACC_W-1:0] p_q    [PIPE_STAGES];
  mac_side_t        side_q [PIPE_STAGES];
  mac_side_t        side_c;

  assign side_c = '{valid: in_valid, is_signed: a_sign | b_sign, clr: clr,
                    mode: mac_mode_e'(mode)};

  // Each lane is widened by one bit that carries the sign only when its operand is signed,
  // so a single signed multiply covers signed, unsigned and mixed operands.
  always_comb begin
    prod_c = '0;
    fa = '0; fb = '0; fp = '0;
    a9 = '0; b9 = '0; p9 = '0;
    a4 = '0; b4 = '0; p4 = '0;
    a2 = '0; b2 = '0; p2 = '0;
    unique case (mac_mode_e'(mode))
      MODE_FULL: begin
        fa = 47'(signed'({a_sign & a[FULL_A_W-1], a[FULL_A_W-1:0]}));
        fb = 47'(signed'({b_sign & b[FULL_B_W-1], b[FULL_B_W-1:0]}));
        fp = fa * fb;
        prod_c = ACC_W'(fp);
      end
      MODE_SUM9: begin
        for (int unsigned k = 0; k < LANE9_N; k++) begin
          a9 = 20'(signed'({a_sign & a[LANE9_W*k+8], a[LANE9_W*k +: LANE9_W]}));
          b9 = 20'(signed'({b_sign & b[LANE9_W*k+8], b[LANE9_W*k +: LANE9_W]}));
          p9 = a9 * b9;
          prod_c = prod_c + ACC_W'(p9);
        end
      end
      MODE_SUM4: begin
        for (int unsigned j = 0; j < LANE4_N; j++) begin
          a4 = 10'(signed'({a_sign & a[LANE4_W*j+3], a[LANE4_W*j +: LANE4_W]}));
          b4 = 10'(signed'({b_sign & b[LANE4_W*j+3], b[LANE4_W*j +: LANE4_W]}));
          p4 = a4 * b4;
          prod_c = prod_c + ACC_W'(p4);
        end
      end
      MODE_SUM2: begin
        for (int unsigned j = 0; j < LANE2_N; j++) begin
          a2 = 6'(signed'({a_sign & a[LANE2_W*j+1], a[LANE2_W*j +: LANE2_W]}));
          b2 = 6'(signed'({b_sign & b[LANE2_W*j+1], b[LANE2_W*j +: LANE2_W]}));
          p2 = a2 * b2;
          prod_c = prod_c + ACC_W'(p2);
        end
      end
    endcase
  end

  // Product delay line; every stage moves only on the shared advance enable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        p_q[i]    <= '0;
        side_q[i] <= '0;
      end
    end else if (adv) begin
      p_q[0]    <= prod_c;
      side_q[0] <= side_c;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        p_q[i]    <= p_q[i-1];
        side_q[i] <= side_q[i-1];
      end
    end
  end

  assign p        = p_q[PIPE_STAGES-1];
  assign p_valid  = side_q[PIPE_STAGES-1].valid;
  assign p_signed = side_q[PIPE_STAGES-1].is_signed;
  assign p_clr    = side_q[PIPE_STAGES-1].clr;
  assign p_mode   = side_q[PIPE_STAGES-1].mode;

endmodule

// File: rtl/simd_mac_pipelined.sv
// Pipelined multi-mode MAC: handshake, accumulator, sticky overflow and mode tracking.
module simd_mac_pipelined
  import pirdsp_mac_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned ACC_W       = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [53:0]      a,
  input  logic [53:0]      b,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [1:0]       mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic [1:0]       acc_mode
);

  logic             adv;
  logic [ACC_W-1:0] p;
  logic             p_valid, p_signed, p_clr;
  logic [1:0]       p_mode;
  mac_mode_e        mode_q;
  logic [ACC_W:0]   sum_c;
  logic             ovf_now;
  logic             restart;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign acc_mode = mode_q;

  simd_product_unit #(
    .PIPE_STAGES (PIPE_STAGES),
    .ACC_W       (ACC_W)
  ) u_prod (
    .clk      (clk),
    .reset_n  (reset_n),
    .adv      (adv),
    .in_valid (in_valid && in_ready),
    .a        (a),
    .b        (b),
    .a_sign   (a_sign),
    .b_sign   (b_sign),
    .mode     (mode),
    .clr      (acc_clr),
    .p        (p),
    .p_valid  (p_valid),
    .p_signed (p_signed),
    .p_clr    (p_clr),
    .p_mode   (p_mode)
  );

  // Next accumulator value and overflow of this add, judged by the beat's signedness.
  always_comb begin
    sum_c   = {1'b0, acc_out} + {1'b0, p};
    restart = p_clr || (mac_mode_e'(p_mode) != mode_q);
    if (p_signed)
      ovf_now = (acc_out[ACC_W-1] == p[ACC_W-1]) && (sum_c[ACC_W-1] != acc_out[ACC_W-1]);
    else
      ovf_now = sum_c[ACC_W];
  end

  // Accumulator stage; holds with the rest of the pipe when the output is stalled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      acc_out   <= '0;
      acc_ovf   <= 1'b0;
      mode_q    <= MODE_FULL;
    end else if (adv) begin
      out_valid <= p_valid;
      if (p_valid) begin
        if (restart) begin
          acc_out <= p;
          acc_ovf <= 1'b0;
          mode_q  <= mac_mode_e'(p_mode);
        end else begin
          acc_out <= sum_c[ACC_W-1:0];
          acc_ovf <= acc_ovf | ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_mac_pipelined.sv
// Scoreboard bench for simd_mac_pipelined using directed vectors.
module tb_simd_mac_pipelined;

  localparam int unsigned PIPE  = 2;
  localparam int unsigned ACC_W = 48;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [53:0]       a, b;
  logic              a_sign, b_sign;
  logic [1:0]        mode;
  logic              acc_clr;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_ovf;
  logic [1:0]        acc_mode;

  always #5 clk = ~clk;

  simd_mac_pipelined #(
    .PIPE_STAGES (PIPE),
    .ACC_W       (ACC_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_sign    (a_sign),
    .b_sign    (b_sign),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .acc_ovf   (acc_ovf),
    .acc_mode  (acc_mode)
  );

  typedef struct {
    logic [47:0] acc;
    logic        ovf;
    logic [1:0]  mode;
    int          issue;
    bit          lat_chk;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per delivered result and checks stall stability.
  logic [47:0] prev_acc;
  logic        prev_ovf;
  logic [1:0]  prev_mode;
  bit          prev_stall = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || acc_out !== prev_acc || acc_ovf !== prev_ovf || acc_mode !== prev_mode) begin
          errors++;
          $display("FAIL hold: valid=%b acc=%h ovf=%b mode=%b expected held acc=%h ovf=%b mode=%b",
                   out_valid, acc_out, acc_ovf, acc_mode, prev_acc, prev_ovf, prev_mode);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: acc=%h with no beat outstanding", acc_out);
        end else begin
          e = sbq.pop_front();
          if (acc_out !== e.acc || acc_ovf !== e.ovf || acc_mode !== e.mode) begin
            errors++;
            $display("FAIL result: acc=%h ovf=%b mode=%b expected acc=%h ovf=%b mode=%b",
                     acc_out, acc_ovf, acc_mode, e.acc, e.ovf, e.mode);
          end
          if (e.lat_chk) begin
            checks++;
            if (cyc - e.issue != int'(PIPE) + 1) begin
              errors++;
              $display("FAIL latency: got %0d cycles expected %0d", cyc - e.issue, PIPE + 1);
            end
          end
        end
      end
      prev_stall = out_valid === 1'b1 && out_ready === 1'b0;
      prev_acc   = acc_out;
      prev_ovf   = acc_ovf;
      prev_mode  = acc_mode;
    end else begin
      prev_stall = 0;
    end
  end

  // Presents one beat, waits (bounded) for acceptance and records its expected result.
  task automatic send(input logic [53:0] av, input logic [53:0] bv, input logic as, input logic bs,
                      input logic [1:0] md, input logic clr, input logic [47:0] e_acc,
                      input logic e_ovf, input bit lat);
    bit done = 0;
    a = av; b = bv; a_sign = as; b_sign = bs; mode = md; acc_clr = clr; in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        done = 1;
        sbq.push_back('{acc: e_acc, ovf: e_ovf, mode: md, issue: cyc, lat_chk: lat});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding expected 0", sbq.size());
      sbq.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_acc_out"},   64'(acc_out),   64'd0);
    chk({tag, "_acc_ovf"},   64'(acc_ovf),   64'd0);
    chk({tag, "_acc_mode"},  64'(acc_mode),  64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
  endtask

  localparam logic [63:0] FULL_P = 64'h1FFF_F7FC_0001; // (2^27-1)*(2^18-1)

  initial begin
    logic [53:0] av, bv;
    logic [63:0] e;
    bit          seen_drop;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; a_sign = 1'b0; b_sign = 1'b0; mode = 2'b00; acc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_reset_state("por");

    // FULL signed: -1 * 3, junk in the ignored upper A bits.
    send({27'h5A5A5A5, 27'h7FFFFFF}, 54'd3, 1'b1, 1'b1, 2'b00, 1'b1, 48'hFFFF_FFFF_FFFD, 1'b0, 1);
    drain();

    // SUM9 unsigned, all lanes 0x1FF.
    send('1, '1, 1'b0, 1'b0, 2'b01, 1'b1, 48'd1566726, 1'b0, 1);
    // SUM9 mixed signs: (-1)*511 per lane, cleared.
    send('1, '1, 1'b1, 1'b0, 2'b01, 1'b1, 48'hFFFF_FFFF_F406, 1'b0, 1);
    drain();

    // SUM2 signed: (-2)*(-2)=4 per lane, 24 lanes, three back-to-back beats.
    av = {6'h3F, {24{2'b10}}};
    send(av, av, 1'b1, 1'b1, 2'b11, 1'b1, 48'd96,  1'b0, 1);
    send(av, av, 1'b1, 1'b1, 2'b11, 1'b0, 48'd192, 1'b0, 1);
    send(av, av, 1'b1, 1'b1, 2'b11, 1'b0, 48'd288, 1'b0, 1);
    drain();

    // Backpressure: five SUM4 beats of 2700 with a 4-cycle downstream stall.
    av = {6'h00, {12{4'hF}}};
    seen_drop = 0;
    fork
      begin
        for (int k = 1; k <= 5; k++)
          send(av, av, 1'b0, 1'b0, 2'b10, (k == 1), 48'(2700 * k), 1'b0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (in_ready === 1'b0) seen_drop = 1;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_dropped", 64'(seen_drop), 64'd1);
    chk("bp_final_acc", 64'(acc_out), 64'd13500);

    // Reset with beats in flight; they must never emerge.
    send(54'd5, 54'd7, 1'b0, 1'b0, 2'b00, 1'b1, 48'd35, 1'b0, 0);
    send(54'd5, 54'd7, 1'b0, 1'b0, 2'b00, 1'b0, 48'd70, 1'b0, 0);
    reset_n = 1'b0;
    sbq.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    check_reset_state("mid");
    repeat (8) begin @(posedge clk); #1; end
    chk("mid_no_stale", 64'(out_valid), 64'd0);

    // FULL unsigned overflow: carry out on the 9th accumulation.
    av = {27'h0, 27'h7FFFFFF};
    bv = {36'h0, 18'h3FFFF};
    for (int k = 1; k <= 9; k++) begin
      e = FULL_P * 64'(k);
      send(av, bv, 1'b0, 1'b0, 2'b00, (k == 1), e[47:0], (k == 9), 0);
    end
    drain();
    chk("ovf_sticky_set", 64'(acc_ovf), 64'd1);

    // Mode change without clear restarts: 2*(1+2+...+6)=42.
    send({9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1}, {6{9'd2}}, 1'b0, 1'b0, 2'b01, 1'b0, 48'd42, 1'b0, 0);
    drain();
    chk("mode_change_ovf", 64'(acc_ovf), 64'd0);
    chk("mode_change_mode", 64'(acc_mode), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
